// File: rtl/axi_wr_channel_scheduler.sv
// Shares one AXI AW/W/B master port between NumPorts write requesters: round-robin AW grant with
// port-tagged IDs, W sequenced by an AW-order FIFO, B routed back by ID tag.
`timescale 1ns / 1ps

module axi_wr_channel_scheduler #(
  parameter int unsigned NumPorts       = 3,
  parameter int unsigned IdWidth        = 4,
  parameter int unsigned MaxOutstanding = 4,
  // AW payload: ID in the low IdWidth bits, the rest of the channel above it
  parameter int unsigned AwWidth        = 12,
  // W payload: last in bit 0
  parameter int unsigned WWidth         = 9,
  localparam int unsigned SelW          = $clog2(NumPorts)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NumPorts-1:0][AwWidth-1:0]   req_aw_i,
  input  logic [NumPorts-1:0]                req_aw_valid_i,
  output logic [NumPorts-1:0]                req_aw_ready_o,
  input  logic [NumPorts-1:0][WWidth-1:0]    req_w_i,
  input  logic [NumPorts-1:0]                req_w_valid_i,
  output logic [NumPorts-1:0]                req_w_ready_o,
  output logic [IdWidth-1:0]                 req_b_id_o,
  output logic [1:0]                         req_b_resp_o,
  output logic [NumPorts-1:0]                req_b_valid_o,
  input  logic [NumPorts-1:0]                req_b_ready_i,
  output logic [AwWidth+SelW-1:0]            aw_o,
  output logic                               aw_valid_o,
  input  logic                               aw_ready_i,
  output logic [WWidth-1:0]                  w_o,
  output logic                               w_valid_o,
  input  logic                               w_ready_i,
  input  logic [IdWidth+SelW-1:0]            b_id_i,
  input  logic [1:0]                         b_resp_i,
  input  logic                               b_valid_i,
  output logic                               b_ready_o,
  output logic                               busy_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  logic [SelW-1:0]               ptr_q, ptr_d;
  logic                          lock_q, lock_d;
  logic [SelW-1:0]               lock_port_q, lock_port_d;
  logic [NumPorts-1:0][CntW-1:0] cnt_q, cnt_d;
  logic [SelW-1:0]               fifo_mem_q [MaxOutstanding];
  logic [PtrW-1:0]               wr_ptr_q, rd_ptr_q, wr_ptr_nxt, rd_ptr_nxt;
  logic [CntW-1:0]               fifo_cnt_q, fifo_cnt_d;

  logic                          fifo_empty, fifo_full;
  logic [SelW-1:0]               head;
  logic [NumPorts-1:0]           eligible;
  logic                          rr_found;
  logic [SelW-1:0]               rr_pick, grant;
  logic                          aw_hs, w_pop, b_hs, b_sel_ok;
  logic [SelW-1:0]               b_sel;

  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_full  = (fifo_cnt_q == CntW'(MaxOutstanding));
  assign head       = fifo_mem_q[rd_ptr_q];

  // AW eligibility and round-robin pick starting at ptr_q
  always_comb begin
    logic [SelW-1:0] idx;
    int unsigned     sum;
    eligible = '0;
    rr_found = 1'b0;
    rr_pick  = '0;
    idx      = '0;
    sum      = 0;
    for (int unsigned p = 0; p < NumPorts; p++) begin
      eligible[p] = req_aw_valid_i[p] && (cnt_q[p] < CntW'(MaxOutstanding)) && !fifo_full;
    end
    for (int unsigned i = 0; i < NumPorts; i++) begin
      sum = 32'(ptr_q) + i;
      if (sum >= NumPorts) sum = sum - NumPorts;
      idx = SelW'(sum);
      if (!rr_found && eligible[idx]) begin
        rr_found = 1'b1;
        rr_pick  = idx;
      end
    end
  end

  // A presented-but-unaccepted AW pins the grant so the payload stays stable
  assign grant      = lock_q ? lock_port_q : rr_pick;
  assign aw_valid_o = lock_q | rr_found;
  assign aw_o       = {req_aw_i[grant][AwWidth-1:IdWidth], grant, req_aw_i[grant][IdWidth-1:0]};
  assign aw_hs      = aw_valid_o & aw_ready_i;

  always_comb begin
    req_aw_ready_o = '0;
    if (aw_valid_o) req_aw_ready_o[grant] = aw_ready_i;
    lock_d      = aw_valid_o & ~aw_ready_i;
    lock_port_d = grant;
    ptr_d       = ptr_q;
    if (aw_hs) ptr_d = (grant == SelW'(NumPorts - 1)) ? '0 : grant + SelW'(1);
  end

  // W follows the AW grant order recorded in the FIFO
  assign w_o        = req_w_i[head];
  assign w_valid_o  = ~fifo_empty & req_w_valid_i[head];
  assign w_pop      = w_valid_o & w_ready_i & w_o[0];
  assign wr_ptr_nxt = (wr_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wr_ptr_q + PtrW'(1);
  assign rd_ptr_nxt = (rd_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rd_ptr_q + PtrW'(1);

  always_comb begin
    req_w_ready_o = '0;
    if (!fifo_empty) req_w_ready_o[head] = w_ready_i;
    fifo_cnt_d = fifo_cnt_q;
    unique case ({aw_hs, w_pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CntW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CntW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // B routing; an out-of-range tag is sunk so the interconnect never stalls
  assign b_sel        = b_id_i[IdWidth +: SelW];
  assign b_sel_ok     = (32'(b_sel) < NumPorts);
  assign req_b_id_o   = b_id_i[IdWidth-1:0];
  assign req_b_resp_o = b_resp_i;
  assign b_hs         = b_valid_i & b_ready_o & b_sel_ok;

  always_comb begin
    req_b_valid_o = '0;
    b_ready_o     = 1'b1;
    if (b_sel_ok) begin
      req_b_valid_o[b_sel] = b_valid_i;
      b_ready_o            = req_b_ready_i[b_sel];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned p = 0; p < NumPorts; p++) begin
      if (aw_hs && (32'(grant) == p) && !(b_hs && (32'(b_sel) == p))) begin
        cnt_d[p] = cnt_q[p] + CntW'(1);
      end else if (b_hs && (32'(b_sel) == p) && !(aw_hs && (32'(grant) == p))
                   && (cnt_q[p] != '0)) begin
        cnt_d[p] = cnt_q[p] - CntW'(1);
      end
    end
  end

  assign busy_o = (|cnt_q) | ~fifo_empty;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q       <= '0;
      lock_q      <= 1'b0;
      lock_port_q <= '0;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      for (int unsigned i = 0; i < MaxOutstanding; i++) fifo_mem_q[i] <= '0;
    end else begin
      ptr_q       <= ptr_d;
      lock_q      <= lock_d;
      lock_port_q <= lock_port_d;
      cnt_q       <= cnt_d;
      fifo_cnt_q  <= fifo_cnt_d;
      if (aw_hs) begin
        fifo_mem_q[wr_ptr_q] <= grant;
        wr_ptr_q             <= wr_ptr_nxt;
      end
      if (w_pop) rd_ptr_q <= rd_ptr_nxt;
    end
  end

`ifndef SYNTHESIS
  a_aw_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (aw_valid_o && !aw_ready_i) |=> $stable(aw_o));
  a_w_nonempty: assert property (@(posedge clk_i) disable iff (rst_i)
    (w_valid_o && w_ready_i) |-> !fifo_empty);
  a_b_tag: assert property (@(posedge clk_i) disable iff (rst_i)
    b_valid_i |-> b_sel_ok);
  a_b_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    b_hs |-> (cnt_q[b_sel] != '0));
`endif

endmodule

// File: tb/tb_axi_wr_channel_scheduler.sv
// Scoreboard bench for axi_wr_channel_scheduler: directed requester traffic, expected AW/W/B
// pushed into queues, a negedge monitor pops and compares on every master/requester handshake.
`timescale 1ns / 1ps

module tb_axi_wr_channel_scheduler;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [2:0][11:0] req_aw_i;
  logic [2:0]       req_aw_valid_i;
  logic [2:0]       req_aw_ready_o;
  logic [2:0][8:0]  req_w_i;
  logic [2:0]       req_w_valid_i;
  logic [2:0]       req_w_ready_o;
  logic [3:0]       req_b_id_o;
  logic [1:0]       req_b_resp_o;
  logic [2:0]       req_b_valid_o;
  logic [2:0]       req_b_ready_i;
  logic [13:0]      aw_o;
  logic             aw_valid_o;
  logic             aw_ready_i;
  logic [8:0]       w_o;
  logic             w_valid_o;
  logic             w_ready_i;
  logic [5:0]       b_id_i;
  logic [1:0]       b_resp_i;
  logic             b_valid_i;
  logic             b_ready_o;
  logic             busy_o;

  axi_wr_channel_scheduler #(
    .NumPorts      (3),
    .IdWidth       (4),
    .MaxOutstanding(4),
    .AwWidth       (12),
    .WWidth        (9)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req_aw_i      (req_aw_i),
    .req_aw_valid_i(req_aw_valid_i),
    .req_aw_ready_o(req_aw_ready_o),
    .req_w_i       (req_w_i),
    .req_w_valid_i (req_w_valid_i),
    .req_w_ready_o (req_w_ready_o),
    .req_b_id_o    (req_b_id_o),
    .req_b_resp_o  (req_b_resp_o),
    .req_b_valid_o (req_b_valid_o),
    .req_b_ready_i (req_b_ready_i),
    .aw_o          (aw_o),
    .aw_valid_o    (aw_valid_o),
    .aw_ready_i    (aw_ready_i),
    .w_o           (w_o),
    .w_valid_o     (w_valid_o),
    .w_ready_i     (w_ready_i),
    .b_id_i        (b_id_i),
    .b_resp_i      (b_resp_i),
    .b_valid_i     (b_valid_i),
    .b_ready_o     (b_ready_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-port requester stimulus FIFOs
  logic [11:0] aw_pend [3][32];
  logic [8:0]  w_pend  [3][32];
  int          aw_wr [3];
  int          aw_rd [3];
  int          w_wr  [3];
  int          w_rd  [3];

  logic [13:0] exp_aw [$];
  logic [8:0]  exp_w  [$];
  logic [8:0]  exp_b  [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  function automatic logic [13:0] awx(input logic [1:0] p, input logic [3:0] id,
                                      input logic [7:0] a);
    return {a, p, id};
  endfunction

  task automatic enq_aw(input int p, input logic [3:0] id, input logic [7:0] a);
    aw_pend[p][aw_wr[p]] = {a, id};
    aw_wr[p]++;
  endtask

  task automatic enq_w(input int p, input logic [7:0] d, input logic last);
    w_pend[p][w_wr[p]] = {d, last};
    w_wr[p]++;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  function automatic bit aw_idle();
    bit r;
    r = (exp_aw.size() == 0);
    for (int p = 0; p < 3; p++) if (aw_rd[p] != aw_wr[p]) r = 1'b0;
    return r;
  endfunction

  function automatic bit all_idle();
    bit r;
    r = aw_idle() && (exp_w.size() == 0);
    for (int p = 0; p < 3; p++) if (w_rd[p] != w_wr[p]) r = 1'b0;
    return r;
  endfunction

  task automatic wait_aw(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      tick();
      done = aw_idle();
    end
    if (!done) fail_now(name);
  endtask

  task automatic wait_drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      tick();
      done = all_idle();
    end
    if (!done) fail_now(name);
  endtask

  task automatic send_b(input logic [5:0] id, input logic [1:0] resp, input logic [2:0] vexp);
    bit got = 1'b0;
    exp_b.push_back({vexp, id[3:0], resp});
    b_valid_i = 1'b1;
    b_id_i    = id;
    b_resp_i  = resp;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk_i);
      got = b_ready_o;
    end
    if (!got) fail_now("b_handshake");
    tick();
    b_valid_i = 1'b0;
  endtask

  // Requester drivers: sample handshakes at negedge, advance/present after the edge
  initial begin
    logic [2:0] aw_hs_s, w_hs_s;
    req_aw_valid_i = '0;
    req_w_valid_i  = '0;
    req_aw_i       = '0;
    req_w_i        = '0;
    for (int p = 0; p < 3; p++) begin
      aw_wr[p] = 0; aw_rd[p] = 0; w_wr[p] = 0; w_rd[p] = 0;
    end
    forever begin
      @(negedge clk_i);
      aw_hs_s = req_aw_valid_i & req_aw_ready_o;
      w_hs_s  = req_w_valid_i & req_w_ready_o;
      @(posedge clk_i);
      #1;
      for (int p = 0; p < 3; p++) begin
        if (aw_hs_s[p]) aw_rd[p]++;
        if (w_hs_s[p]) w_rd[p]++;
        req_aw_valid_i[p] = (aw_rd[p] != aw_wr[p]);
        req_aw_i[p]       = req_aw_valid_i[p] ? aw_pend[p][aw_rd[p]] : 12'h0;
        req_w_valid_i[p]  = (w_rd[p] != w_wr[p]);
        req_w_i[p]        = req_w_valid_i[p] ? w_pend[p][w_rd[p]] : 9'h0;
      end
    end
  end

  // Scoreboard monitor
  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        if (aw_valid_o && aw_ready_i) begin
          if (exp_aw.size() == 0) fail_now("aw_unexpected");
          else chk("aw_payload", 32'(aw_o), 32'(exp_aw.pop_front()));
        end
        if (w_valid_o && w_ready_i) begin
          if (exp_w.size() == 0) fail_now("w_unexpected");
          else chk("w_payload", 32'(w_o), 32'(exp_w.pop_front()));
        end
        if (b_valid_i && b_ready_o) begin
          if (exp_b.size() == 0) fail_now("b_unexpected");
          else chk("b_route", 32'({req_b_valid_o, req_b_id_o, req_b_resp_o}),
                   32'(exp_b.pop_front()));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin
    rst_i         = 1'b1;
    aw_ready_i    = 1'b0;
    w_ready_i     = 1'b0;
    b_valid_i     = 1'b0;
    b_id_i        = '0;
    b_resp_i      = '0;
    req_b_ready_i = 3'b111;
    repeat (3) tick();
    @(negedge clk_i);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_aw_valid", 32'(aw_valid_o), 0);
    chk("rst_w_valid", 32'(w_valid_o), 0);
    chk("rst_aw_ready", 32'(req_aw_ready_o), 0);
    tick();
    rst_i = 1'b0;

    // 1: simultaneous AW from all ports, grants 0,1,2 on consecutive cycles
    aw_ready_i = 1'b1;
    w_ready_i  = 1'b1;
    enq_aw(0, 4'h1, 8'h10); enq_aw(1, 4'h2, 8'h21); enq_aw(2, 4'h3, 8'h32);
    exp_aw.push_back(awx(2'd0, 4'h1, 8'h10));
    exp_aw.push_back(awx(2'd1, 4'h2, 8'h21));
    exp_aw.push_back(awx(2'd2, 4'h3, 8'h32));
    enq_w(0, 8'hD0, 1'b1); enq_w(1, 8'hD1, 1'b1); enq_w(2, 8'hD2, 1'b1);
    exp_w.push_back({8'hD0, 1'b1}); exp_w.push_back({8'hD1, 1'b1});
    exp_w.push_back({8'hD2, 1'b1});
    tick();
    @(negedge clk_i); chk("t1_grant0", 32'(req_aw_ready_o), 32'b001);
    @(negedge clk_i); chk("t1_grant1", 32'(req_aw_ready_o), 32'b010);
    @(negedge clk_i); chk("t1_grant2", 32'(req_aw_ready_o), 32'b100);
    wait_drain("t1_drain");
    @(negedge clk_i); chk("t1_busy", 32'(busy_o), 1);
    tick();
    send_b(6'h01, 2'b00, 3'b001);
    send_b(6'h12, 2'b01, 3'b010);
    send_b(6'h23, 2'b10, 3'b100);
    @(negedge clk_i); chk("t1_idle", 32'(busy_o), 0);
    tick();

    // 2: stalled AW from port 1 stays locked while port 0 raises valid
    aw_ready_i = 1'b0;
    enq_aw(1, 4'h5, 8'h41);
    exp_aw.push_back(awx(2'd1, 4'h5, 8'h41));
    exp_aw.push_back(awx(2'd0, 4'h6, 8'h50));
    enq_w(1, 8'hD3, 1'b1); enq_w(0, 8'hD4, 1'b1);
    exp_w.push_back({8'hD3, 1'b1}); exp_w.push_back({8'hD4, 1'b1});
    tick();
    enq_aw(0, 4'h6, 8'h50);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("t2_lock_payload", 32'(aw_o), 32'(awx(2'd1, 4'h5, 8'h41)));
      chk("t2_lock_valid", 32'(aw_valid_o), 1);
    end
    tick();
    aw_ready_i = 1'b1;
    wait_drain("t2_drain");
    send_b(6'h15, 2'b00, 3'b010);
    send_b(6'h06, 2'b00, 3'b001);

    // 3: port 2 four-beat burst precedes port 0 single beat
    w_ready_i = 1'b0;
    enq_aw(2, 4'hA, 8'h6A);
    exp_aw.push_back(awx(2'd2, 4'hA, 8'h6A));
    enq_w(2, 8'hE0, 1'b0); enq_w(2, 8'hE1, 1'b0); enq_w(2, 8'hE2, 1'b0); enq_w(2, 8'hE3, 1'b1);
    enq_w(0, 8'hE4, 1'b1);
    exp_w.push_back({8'hE0, 1'b0}); exp_w.push_back({8'hE1, 1'b0});
    exp_w.push_back({8'hE2, 1'b0}); exp_w.push_back({8'hE3, 1'b1});
    exp_w.push_back({8'hE4, 1'b1});
    wait_aw("t3_aw2");
    enq_aw(0, 4'hB, 8'h7B);
    exp_aw.push_back(awx(2'd0, 4'hB, 8'h7B));
    wait_aw("t3_aw0");
    @(negedge clk_i);
    chk("t3_w_valid", 32'(w_valid_o), 1);
    chk("t3_w_head", 32'(w_o), 32'({8'hE0, 1'b0}));
    tick();
    w_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i); chk("t3_w_ready_p2", 32'(req_w_ready_o), 32'b100);
    end
    @(negedge clk_i); chk("t3_w_ready_p0", 32'(req_w_ready_o), 32'b001);
    wait_drain("t3_drain");
    send_b(6'h2A, 2'b00, 3'b100);
    send_b(6'h0B, 2'b11, 3'b001);

    // 4: port 0 at outstanding limit; port 1 still served; one B unblocks port 0
    for (int i = 0; i < 4; i++) begin
      enq_aw(0, 4'(i), 8'(8'h80 + i));
      exp_aw.push_back(awx(2'd0, 4'(i), 8'(8'h80 + i)));
      enq_w(0, 8'(8'hF0 + i), 1'b1);
      exp_w.push_back({8'(8'hF0 + i), 1'b1});
    end
    wait_drain("t4_fill");
    enq_aw(0, 4'h4, 8'h84); enq_aw(1, 4'h7, 8'h97);
    enq_w(0, 8'hF4, 1'b1); enq_w(1, 8'hF5, 1'b1);
    exp_aw.push_back(awx(2'd1, 4'h7, 8'h97));
    exp_aw.push_back(awx(2'd0, 4'h4, 8'h84));
    exp_w.push_back({8'hF5, 1'b1}); exp_w.push_back({8'hF4, 1'b1});
    repeat (4) tick();
    @(negedge clk_i);
    chk("t4_p0_held", 32'(req_aw_ready_o), 0);
    chk("t4_aw_idle", 32'(aw_valid_o), 0);
    tick();
    send_b(6'h03, 2'b00, 3'b001);
    @(negedge clk_i);
    chk("t4_p0_regrant", 32'(aw_o), 32'(awx(2'd0, 4'h4, 8'h84)));
    chk("t4_p0_ready", 32'(req_aw_ready_o), 32'b001);
    tick();
    wait_drain("t4_drain");
    send_b(6'h00, 2'b00, 3'b001);
    send_b(6'h01, 2'b10, 3'b001);
    send_b(6'h02, 2'b00, 3'b001);
    send_b(6'h17, 2'b01, 3'b010);
    send_b(6'h04, 2'b00, 3'b001);
    @(negedge clk_i); chk("t4_idle", 32'(busy_o), 0);
    tick();

    // 5: B backpressure on port 1, then B and AW for port 1 in the same cycle
    enq_aw(1, 4'h5, 8'hA5);
    exp_aw.push_back(awx(2'd1, 4'h5, 8'hA5));
    enq_w(1, 8'hC1, 1'b1);
    exp_w.push_back({8'hC1, 1'b1});
    wait_drain("t5_first");
    aw_ready_i = 1'b0;
    enq_aw(1, 4'h9, 8'hA9);
    exp_aw.push_back(awx(2'd1, 4'h9, 8'hA9));
    enq_w(1, 8'hC2, 1'b1);
    exp_w.push_back({8'hC2, 1'b1});
    req_b_ready_i = 3'b101;
    b_valid_i     = 1'b1;
    b_id_i        = 6'h15;
    b_resp_i      = 2'b01;
    exp_b.push_back({3'b010, 4'h5, 2'b01});
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      chk("t5_b_ready", 32'(b_ready_o), 0);
      chk("t5_b_valid", 32'(req_b_valid_o), 32'b010);
      chk("t5_b_id", 32'(req_b_id_o), 32'h5);
    end
    tick();
    req_b_ready_i = 3'b111;
    aw_ready_i    = 1'b1;
    @(negedge clk_i);
    tick();
    b_valid_i = 1'b0;
    wait_drain("t5_drain");
    @(negedge clk_i); chk("t5_cnt_kept", 32'(busy_o), 1);
    tick();
    send_b(6'h19, 2'b00, 3'b010);
    @(negedge clk_i); chk("t5_idle", 32'(busy_o), 0);
    tick();

    // 6: reset with two bursts outstanding clears state and the RR pointer
    enq_aw(0, 4'h1, 8'hB1); enq_aw(1, 4'h2, 8'hB2);
    exp_aw.push_back(awx(2'd0, 4'h1, 8'hB1));
    exp_aw.push_back(awx(2'd1, 4'h2, 8'hB2));
    wait_aw("t6_aw");
    @(negedge clk_i); chk("t6_busy_pre", 32'(busy_o), 1);
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("t6_busy", 32'(busy_o), 0);
    chk("t6_aw_valid", 32'(aw_valid_o), 0);
    chk("t6_w_valid", 32'(w_valid_o), 0);
    chk("t6_w_ready", 32'(req_w_ready_o), 0);
    tick();
    enq_aw(1, 4'h3, 8'hC3); enq_aw(2, 4'h4, 8'hC4);
    exp_aw.push_back(awx(2'd1, 4'h3, 8'hC3));
    exp_aw.push_back(awx(2'd2, 4'h4, 8'hC4));
    enq_w(1, 8'h31, 1'b1); enq_w(2, 8'h42, 1'b1);
    exp_w.push_back({8'h31, 1'b1}); exp_w.push_back({8'h42, 1'b1});
    wait_drain("t6_drain");
    send_b(6'h13, 2'b00, 3'b010);
    send_b(6'h24, 2'b00, 3'b100);
    @(negedge clk_i); chk("t6_idle", 32'(busy_o), 0);

    chk("left_aw", 32'(exp_aw.size()), 0);
    chk("left_w", 32'(exp_w.size()), 0);
    chk("left_b", 32'(exp_b.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
